// File: rtl/stream_framer.sv
// Packs a no-backpressure word stream into framed output:
// SYNC_WORD, sequence header, PAYLOAD_LEN payload words, checksum.
module stream_framer #(
  parameter int              WIDTH       = 16,
  parameter int              PAYLOAD_LEN = 8,
  parameter int              FIFO_DEPTH  = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 'hEB90
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             dval,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             sof,
  output logic             eof,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic [7:0]       drop_count,
  output logic [WIDTH-1:0] frame_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int NW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PLEN_C  = CW'(PAYLOAD_LEN);
  localparam logic [NW-1:0] PLEN_N  = NW'(PAYLOAD_LEN);

  typedef enum logic [2:0] {
    IDLE, SYNC, HEADER, PAYLOAD, CHECKSUM
  } state_t;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, drop, pop;
  logic [WIDTH-1:0] head;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic [WIDTH-1:0] seq_q, seq_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [NW-1:0]    nwords_q, nwords_d;
  logic [WIDTH-1:0] fcnt_q, fcnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drops_q, drops_d;
  logic             xfer;
  logic             have_frame;

  // A full FIFO drops the word even if a pop frees a slot this cycle
  assign push = dval && (cnt_q < DEPTH_C);
  assign drop = dval && !push;
  assign head = mem_q[rd_ptr_q];
  assign xfer = valid_q && dout_ready;
  assign have_frame = (cnt_q >= PLEN_C);

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d   = overflow_clr ? 1'b0 : ovf_q;
    drops_d = overflow_clr ? 8'd0 : drops_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_d != 8'hFF) drops_d = drops_d + 8'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    seq_d    = seq_q;
    acc_d    = acc_q;
    nwords_d = nwords_q;
    fcnt_d   = fcnt_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (have_frame) begin
          dout_d  = SYNC_WORD;
          sof_d   = 1'b1;
          eof_d   = 1'b0;
          valid_d = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (xfer) begin
          dout_d  = seq_q;
          sof_d   = 1'b0;
          acc_d   = seq_q;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (xfer) begin
          pop      = 1'b1;
          dout_d   = head;
          acc_d    = acc_q + head;
          nwords_d = NW'(1);
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (nwords_q < PLEN_N) begin
            pop      = 1'b1;
            dout_d   = head;
            acc_d    = acc_q + head;
            nwords_d = nwords_q + 1'b1;
          end else begin
            dout_d  = acc_q;
            eof_d   = 1'b1;
            state_d = CHECKSUM;
          end
        end
      end
      CHECKSUM: begin
        if (xfer) begin
          seq_d  = seq_q + 1'b1;
          fcnt_d = fcnt_q + 1'b1;
          eof_d  = 1'b0;
          if (have_frame) begin
            dout_d  = SYNC_WORD;
            sof_d   = 1'b1;
            state_d = SYNC;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      seq_q    <= '0;
      acc_q    <= '0;
      nwords_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      seq_q    <= seq_d;
      acc_q    <= acc_d;
      nwords_q <= nwords_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
      drops_q  <= drops_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign overflow    = ovf_q;
  assign drop_count  = drops_q;
  assign frame_count = fcnt_q;

endmodule
